// File: rtl/hp_frame_buf.sv
// Ping-pong frame buffer behind the high-pass pre-filter. One bank fills from the
// ce/data stream while the other holds a finished frame for random-access reads.
module hp_frame_buf #(
    parameter int DW        = 64,
    parameter int FRAME_LEN = 80,
    parameter int AW        = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [DW-1:0] data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          frame_rel,
    input  logic          ovf_clr,
    output logic [DW-1:0] data_out,
    output logic          oe,
    output logic          frame_rdy,
    output logic [15:0]   frame_num,
    output logic          ovf
);

    typedef enum logic {FILL, STALL} wr_state_t;

    localparam logic [AW-1:0] LAST_IDX  = AW'(FRAME_LEN - 1);
    localparam logic [AW:0]   FRAME_EXT = (AW + 1)'(FRAME_LEN);

    wr_state_t     state, state_nxt;
    logic          wr_bank, rd_bank, next_bank;
    logic [AW-1:0] wr_idx;
    logic [1:0]    bank_full, bank_full_nxt;
    logic          write_en, frame_done, drop, rd_accept, rel_accept, addr_ok;

    logic [DW-1:0] mem [2][FRAME_LEN];

    assign frame_rdy  = bank_full[rd_bank];
    assign next_bank  = ~wr_bank;
    assign write_en   = ce && (state == FILL);
    assign frame_done = write_en && (wr_idx == LAST_IDX);
    assign drop       = ce && (state == STALL);
    assign rd_accept  = rd_en && frame_rdy;
    assign rel_accept = frame_rel && frame_rdy;
    assign addr_ok    = ({1'b0, rd_addr} < FRAME_EXT);

    // A bank being released in the same cycle the other bank completes counts as
    // free, so back-to-back frames with prompt release never stall the writer.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (frame_done && bank_full[next_bank] &&
                    !(rel_accept && (rd_bank == next_bank)))
                    state_nxt = STALL;
            end
            STALL: begin
                if (!bank_full[wr_bank])
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        bank_full_nxt = bank_full;
        if (rel_accept)
            bank_full_nxt[rd_bank] = 1'b0;
        if (frame_done)
            bank_full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            bank_full <= '0;
            frame_num <= '0;
            ovf       <= 1'b0;
            data_out  <= '0;
            oe        <= 1'b0;
        end else begin
            state     <= state_nxt;
            bank_full <= bank_full_nxt;

            if (write_en) begin
                if (frame_done) begin
                    wr_idx    <= '0;
                    wr_bank   <= next_bank;
                    frame_num <= frame_num + 16'd1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            if (rel_accept)
                rd_bank <= ~rd_bank;

            // Out-of-range reads still answer, with zero, so the consumer never waits.
            oe <= rd_accept;
            if (rd_accept)
                data_out <= addr_ok ? mem[rd_bank][rd_addr] : '0;

            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en)
            mem[wr_bank][wr_idx] <= data;
    end

endmodule
